// File: rtl/mmu_pkg.sv
// Shared MMU types and constants for the SV39 page-table walker and the TLB.
package mmu_pkg;

  localparam int PAGE_LVL_BITS = 9;

  localparam logic [1:0] GIGA_PAGE = 2'd2;
  localparam logic [1:0] MEGA_PAGE = 2'd1;
  localparam logic [1:0] KILO_PAGE = 2'd0;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } sv39_pte_t;

  typedef enum logic [2:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    WRITE_REQ,
    WRITE_WAIT,
    RESP
  } ptw_state_t;

endpackage

// File: rtl/ptw_sv39_pte_check.sv
// Combinational classification of a fetched SV39 PTE: fault, leaf, or leaf
// that still needs its A/D bits written back.
module ptw_sv39_pte_check
  import mmu_pkg::*;
(
  input  sv39_pte_t  pte_i,
  input  logic [1:0] lvl_i,
  input  logic       store_i,
  output logic       error_o,
  output logic       leaf_o,
  output logic       need_update_o
);

  logic unused_bits;
  assign unused_bits = ^{pte_i.reserved, pte_i.rsw, pte_i.g, pte_i.u, pte_i.ppn[43:18]};

  always_comb begin
    error_o       = 1'b0;
    leaf_o        = pte_i.r | pte_i.x;
    need_update_o = 1'b0;
    if (!pte_i.v || (!pte_i.r && pte_i.w)) begin
      error_o = 1'b1;
    end else if (!leaf_o) begin
      error_o = (lvl_i == KILO_PAGE);
    end else if ((lvl_i == GIGA_PAGE && pte_i.ppn[17:0] != 18'd0) ||
                 (lvl_i == MEGA_PAGE && pte_i.ppn[8:0] != 9'd0)) begin
      // Superpage leaves must have their low PPN fields cleared
      error_o = 1'b1;
    end else begin
      need_update_o = !pte_i.a || (store_i && !pte_i.d && pte_i.w);
    end
  end

endmodule

// File: rtl/ptw_sv39.sv
// SV39 page-table walker: serves one TLB miss at a time, reads up to three
// PTEs, writes back A/D when required and returns the leaf PTE and its level.
module ptw_sv39
  import mmu_pkg::*;
#(
  parameter int PADDR_SIZE = 56,
  parameter int PPN_SIZE   = 44,
  parameter int VPN_SIZE   = 27,
  parameter int ASID_SIZE  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [PPN_SIZE-1:0]   satp_ppn_i,
  input  logic                  flush_i,
  input  logic                  tlb_req_valid_i,
  input  logic [VPN_SIZE-1:0]   tlb_req_vpn_i,
  input  logic [ASID_SIZE-1:0]  tlb_req_asid_i,
  input  logic                  tlb_req_store_i,
  input  logic                  tlb_req_fetch_i,
  output logic                  ptw_ready_o,
  output logic                  invalidate_tlb_o,
  output logic                  resp_valid_o,
  output logic                  resp_error_o,
  output logic [63:0]           resp_pte_o,
  output logic [1:0]            resp_level_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [PADDR_SIZE-1:0] mem_req_addr_o,
  output logic                  mem_req_we_o,
  output logic [63:0]           mem_req_wdata_o,
  input  logic                  mem_resp_valid_i,
  input  logic [63:0]           mem_resp_data_i
);

  ptw_state_t            state_q, state_d;
  logic [PPN_SIZE-1:0]   ppn_q, ppn_d;
  logic [1:0]            lvl_q, lvl_d;
  logic [VPN_SIZE-1:0]   vpn_q, vpn_d;
  logic                  store_q, store_d;
  logic                  fetch_q, fetch_d;
  sv39_pte_t             pte_q, pte_d;
  logic                  err_q, err_d;

  sv39_pte_t             mem_pte;
  logic                  chk_error;
  logic                  chk_leaf;
  logic                  chk_need_update;
  logic [PAGE_LVL_BITS-1:0] vpn_idx;
  logic [PADDR_SIZE-1:0] pte_addr;

  logic unused_ok;
  assign unused_ok = ^{tlb_req_asid_i, fetch_q};

  assign mem_pte = mem_resp_data_i;

  ptw_sv39_pte_check u_pte_check (
    .pte_i         (mem_pte),
    .lvl_i         (lvl_q),
    .store_i       (store_q),
    .error_o       (chk_error),
    .leaf_o        (chk_leaf),
    .need_update_o (chk_need_update)
  );

  always_comb begin
    case (lvl_q)
      GIGA_PAGE: vpn_idx = vpn_q[26:18];
      MEGA_PAGE: vpn_idx = vpn_q[17:9];
      default:   vpn_idx = vpn_q[8:0];
    endcase
  end

  assign pte_addr = {ppn_q, vpn_idx, 3'b000};

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      ppn_q   <= '0;
      lvl_q   <= '0;
      vpn_q   <= '0;
      store_q <= 1'b0;
      fetch_q <= 1'b0;
      pte_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ppn_q   <= ppn_d;
      lvl_q   <= lvl_d;
      vpn_q   <= vpn_d;
      store_q <= store_d;
      fetch_q <= fetch_d;
      pte_q   <= pte_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ppn_d   = ppn_q;
    lvl_d   = lvl_q;
    vpn_d   = vpn_q;
    store_d = store_q;
    fetch_d = fetch_q;
    pte_d   = pte_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (tlb_req_valid_i) begin
          vpn_d   = tlb_req_vpn_i;
          store_d = tlb_req_store_i;
          fetch_d = tlb_req_fetch_i;
          ppn_d   = satp_ppn_i;
          lvl_d   = GIGA_PAGE;
          pte_d   = '0;
          err_d   = 1'b0;
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_req_ready_i) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_resp_valid_i) begin
          if (chk_error) begin
            err_d   = 1'b1;
            pte_d   = '0;
            state_d = RESP;
          end else if (!chk_leaf) begin
            ppn_d   = mem_pte.ppn;
            lvl_d   = lvl_q - 2'd1;
            state_d = MEM_REQ;
          end else begin
            // pte_q doubles as the write-back data, so A/D are set here
            pte_d = mem_pte;
            if (chk_need_update) begin
              pte_d.a = 1'b1;
              if (store_q) pte_d.d = 1'b1;
              state_d = WRITE_REQ;
            end else begin
              state_d = RESP;
            end
          end
        end
      end
      WRITE_REQ: begin
        if (mem_req_ready_i) state_d = WRITE_WAIT;
      end
      WRITE_WAIT: begin
        if (mem_resp_valid_i) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ptw_ready_o      = (state_q == IDLE);
  assign invalidate_tlb_o = flush_i;
  assign mem_req_valid_o  = (state_q == MEM_REQ) || (state_q == WRITE_REQ);
  assign mem_req_we_o     = (state_q == WRITE_REQ);
  assign mem_req_addr_o   = mem_req_valid_o ? pte_addr : '0;
  assign mem_req_wdata_o  = mem_req_we_o ? pte_q : 64'd0;
  assign resp_valid_o     = (state_q == RESP);
  assign resp_error_o     = resp_valid_o & err_q;
  assign resp_pte_o       = resp_valid_o ? pte_q : 64'd0;
  assign resp_level_o     = resp_valid_o ? lvl_q : 2'd0;

endmodule

// File: tb/tb_ptw_sv39.sv
// Self-checking bench for ptw_sv39: table of directed walks against a
// zero-wait memory model, plus hand-written backpressure and reset sequences.
module tb_ptw_sv39;

  localparam logic [43:0] SATP = 44'h80000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [43:0] satp_ppn_i;
  logic        flush_i;
  logic        tlb_req_valid_i;
  logic [26:0] tlb_req_vpn_i;
  logic [15:0] tlb_req_asid_i;
  logic        tlb_req_store_i;
  logic        tlb_req_fetch_i;
  logic        ptw_ready_o;
  logic        invalidate_tlb_o;
  logic        resp_valid_o;
  logic        resp_error_o;
  logic [63:0] resp_pte_o;
  logic [1:0]  resp_level_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [55:0] mem_req_addr_o;
  logic        mem_req_we_o;
  logic [63:0] mem_req_wdata_o;
  logic        mem_resp_valid_i;
  logic [63:0] mem_resp_data_i;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string            name;
    logic [26:0]      vpn;
    logic             store;
    logic [2:0][63:0] rd_data;
    logic [2:0][55:0] rd_addr;
    int               n_rd;
    int               n_wr;
    logic [63:0]      wdata;
    logic [63:0]      exp_pte;
    logic [1:0]       exp_lvl;
    logic             exp_err;
    int               exp_lat;
    int               stall;
    int               flush_at;
  } vec_t;

  vec_t vq[$];

  ptw_sv39 dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .satp_ppn_i       (satp_ppn_i),
    .flush_i          (flush_i),
    .tlb_req_valid_i  (tlb_req_valid_i),
    .tlb_req_vpn_i    (tlb_req_vpn_i),
    .tlb_req_asid_i   (tlb_req_asid_i),
    .tlb_req_store_i  (tlb_req_store_i),
    .tlb_req_fetch_i  (tlb_req_fetch_i),
    .ptw_ready_o      (ptw_ready_o),
    .invalidate_tlb_o (invalidate_tlb_o),
    .resp_valid_o     (resp_valid_o),
    .resp_error_o     (resp_error_o),
    .resp_pte_o       (resp_pte_o),
    .resp_level_o     (resp_level_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_we_o     (mem_req_we_o),
    .mem_req_wdata_o  (mem_req_wdata_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [26:0] vpn, input logic store,
                         input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                         input logic [55:0] a0, input logic [55:0] a1, input logic [55:0] a2,
                         input int n_rd, input int n_wr, input logic [63:0] wdata,
                         input logic [63:0] exp_pte, input logic [1:0] exp_lvl, input logic exp_err,
                         input int exp_lat, input int stall, input int flush_at);
    vec_t v;
    v.name = name; v.vpn = vpn; v.store = store;
    v.rd_data[0] = d0; v.rd_data[1] = d1; v.rd_data[2] = d2;
    v.rd_addr[0] = a0; v.rd_addr[1] = a1; v.rd_addr[2] = a2;
    v.n_rd = n_rd; v.n_wr = n_wr; v.wdata = wdata;
    v.exp_pte = exp_pte; v.exp_lvl = exp_lvl; v.exp_err = exp_err;
    v.exp_lat = exp_lat; v.stall = stall; v.flush_at = flush_at;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    tlb_req_valid_i  = 1'b0;
    tlb_req_vpn_i    = '0;
    tlb_req_asid_i   = '0;
    tlb_req_store_i  = 1'b0;
    tlb_req_fetch_i  = 1'b0;
    flush_i          = 1'b0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
  endtask

  // One walk against a zero-wait memory; response data follows a handshake by one cycle
  task automatic apply_stimulus(input vec_t v);
    int          rd_cnt     = 0;
    int          wr_cnt     = 0;
    int          cyc        = 0;
    int          resp_cyc   = -1;
    bit          hs_pending = 0;
    bit          hs_we      = 0;
    logic [55:0] last_rd    = '0;
    logic [63:0] got_pte    = '0;
    logic [1:0]  got_lvl    = '0;
    logic        got_err    = 1'b0;
    @(negedge clk);
    tlb_req_valid_i  = 1'b1;
    tlb_req_vpn_i    = v.vpn;
    tlb_req_store_i  = v.store;
    tlb_req_asid_i   = 16'h1234;
    satp_ppn_i       = SATP;
    flush_i          = (v.flush_at == 0);
    mem_req_ready_i  = (v.stall == 0);
    mem_resp_valid_i = 1'b0;
    #1;
    check_output({v.name, "/ready"}, ptw_ready_o, 1);
    if (v.flush_at == 0) check_output({v.name, "/inval"}, invalidate_tlb_o, 1);
    while (resp_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      tlb_req_valid_i  = 1'b0;
      flush_i          = (cyc == v.flush_at);
      mem_req_ready_i  = (cyc > v.stall);
      mem_resp_valid_i = hs_pending;
      mem_resp_data_i  = (hs_pending && !hs_we && rd_cnt >= 1 && rd_cnt <= 3) ? v.rd_data[rd_cnt-1] : 64'd0;
      hs_pending       = 0;
      #1;
      if (flush_i) check_output({v.name, "/inval"}, invalidate_tlb_o, 1);
      if (cyc <= v.stall) begin
        check_output({v.name, "/stall_valid"}, mem_req_valid_o, 1);
        check_output({v.name, "/stall_addr"}, mem_req_addr_o, v.rd_addr[0]);
      end
      if (mem_req_valid_o && mem_req_ready_i) begin
        hs_pending = 1;
        hs_we      = mem_req_we_o;
        if (!mem_req_we_o) begin
          if (rd_cnt < 3) check_output({v.name, "/rd_addr"}, mem_req_addr_o, v.rd_addr[rd_cnt]);
          rd_cnt++;
          last_rd = mem_req_addr_o;
        end else begin
          wr_cnt++;
          check_output({v.name, "/wr_addr"}, mem_req_addr_o, last_rd);
          check_output({v.name, "/wdata"}, mem_req_wdata_o, v.wdata);
        end
      end
      if (resp_valid_o) begin
        resp_cyc = cyc;
        got_pte  = resp_pte_o;
        got_lvl  = resp_level_o;
        got_err  = resp_error_o;
        check_output({v.name, "/excl_valid"}, mem_req_valid_o, 0);
      end
    end
    check_output({v.name, "/latency"}, resp_cyc, v.exp_lat);
    check_output({v.name, "/reads"}, rd_cnt, v.n_rd);
    check_output({v.name, "/writes"}, wr_cnt, v.n_wr);
    check_output({v.name, "/pte"}, got_pte, v.exp_pte);
    check_output({v.name, "/level"}, got_lvl, v.exp_lvl);
    check_output({v.name, "/error"}, got_err, v.exp_err);
    @(negedge clk);
    idle_inputs();
    #1;
    check_output({v.name, "/ready_after"}, ptw_ready_o, 1);
  endtask

  initial begin
    rstn       = 1'b0;
    satp_ppn_i = SATP;
    idle_inputs();

    //      name        vpn       st  d0            d1            d2            a0            a1            a2            rd wr wdata         pte           lvl  err lat stl fl
    add_vec("walk4k",   27'h1,    0, 64'h20000401, 64'h20000801, 64'h200400D7, 56'h80000000, 56'h80001000, 56'h80002008, 3, 0, 64'h0,        64'h200400D7, 2'd0, 0, 7,  0, -1);
    add_vec("giga",     27'h40000,0, 64'h200000CF, 64'h0,        64'h0,        56'h80000008, 56'h0,        56'h0,        1, 0, 64'h0,        64'h200000CF, 2'd2, 0, 3,  0, -1);
    add_vec("giga_mis", 27'h40000,0, 64'h200004CF, 64'h0,        64'h0,        56'h80000008, 56'h0,        56'h0,        1, 0, 64'h0,        64'h0,        2'd2, 1, 3,  0, -1);
    add_vec("dirty",    27'h1,    1, 64'h20000401, 64'h20000801, 64'h20040057, 56'h80000000, 56'h80001000, 56'h80002008, 3, 1, 64'h200400D7, 64'h200400D7, 2'd0, 0, 9,  0, -1);
    add_vec("accessed", 27'h40000,0, 64'h2000008F, 64'h0,        64'h0,        56'h80000008, 56'h0,        56'h0,        1, 1, 64'h200000CF, 64'h200000CF, 2'd2, 0, 5,  0, -1);
    add_vec("l1_inval", 27'h1,    0, 64'h20000401, 64'h0,        64'h0,        56'h80000000, 56'h80001000, 56'h0,        2, 0, 64'h0,        64'h0,        2'd1, 1, 5,  0, -1);
    add_vec("l0_nonlf", 27'h1,    0, 64'h20000401, 64'h20000801, 64'h20000801, 56'h80000000, 56'h80001000, 56'h80002008, 3, 0, 64'h0,        64'h0,        2'd0, 1, 7,  0, -1);
    add_vec("stall5",   27'h1,    0, 64'h20000401, 64'h20000801, 64'h200400D7, 56'h80000000, 56'h80001000, 56'h80002008, 3, 0, 64'h0,        64'h200400D7, 2'd0, 0, 12, 5, -1);
    add_vec("flush_mw", 27'h1,    0, 64'h20000401, 64'h20000801, 64'h200400D7, 56'h80000000, 56'h80001000, 56'h80002008, 3, 0, 64'h0,        64'h200400D7, 2'd0, 0, 7,  0, 2);
    add_vec("flush_acc",27'h40000,0, 64'h200000CF, 64'h0,        64'h0,        56'h80000008, 56'h0,        56'h0,        1, 0, 64'h0,        64'h200000CF, 2'd2, 0, 3,  0, 0);

    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    check_output("reset/ready", ptw_ready_o, 1);
    check_output("reset/mem_valid", mem_req_valid_o, 0);
    check_output("reset/resp_valid", resp_valid_o, 0);
    check_output("reset/addr", mem_req_addr_o, 0);
    check_output("reset/resp_pte", resp_pte_o, 0);

    foreach (vq[i]) apply_stimulus(vq[i]);

    // A second request while a walk is stalled must be ignored
    @(negedge clk);
    tlb_req_valid_i = 1'b1; tlb_req_vpn_i = 27'h40000; tlb_req_store_i = 1'b0;
    mem_req_ready_i = 1'b0;
    @(negedge clk);
    tlb_req_vpn_i = 27'h1;
    #1;
    check_output("busy/ready", ptw_ready_o, 0);
    check_output("busy/addr1", mem_req_addr_o, 56'h80000008);
    @(negedge clk);
    #1;
    check_output("busy/addr2", mem_req_addr_o, 56'h80000008);
    check_output("busy/valid", mem_req_valid_o, 1);
    @(negedge clk);
    tlb_req_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'h200000CF;
    @(negedge clk);
    mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    #1;
    check_output("busy/resp_valid", resp_valid_o, 1);
    check_output("busy/resp_pte", resp_pte_o, 64'h200000CF);
    check_output("busy/resp_level", resp_level_o, 2'd2);
    @(negedge clk);
    #1;
    check_output("busy/no_second", mem_req_valid_o, 0);
    check_output("busy/idle", ptw_ready_o, 1);

    // Reset while waiting for read data aborts the walk
    @(negedge clk);
    tlb_req_valid_i = 1'b1; tlb_req_vpn_i = 27'h1; mem_req_ready_i = 1'b1;
    @(negedge clk);
    tlb_req_valid_i = 1'b0;
    #1;
    check_output("rst_mid/req", mem_req_valid_o, 1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'h20000401;
    #1;
    check_output("rst_mid/ready", ptw_ready_o, 1);
    check_output("rst_mid/mem_valid", mem_req_valid_o, 0);
    check_output("rst_mid/addr", mem_req_addr_o, 0);
    check_output("rst_mid/resp_valid", resp_valid_o, 0);
    check_output("rst_mid/resp_pte", resp_pte_o, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
      #1;
      check_output("rst_mid/late_resp", resp_valid_o, 0);
      check_output("rst_mid/late_mem", mem_req_valid_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
